// File: rtl/gcd_calculator_if.sv
// Purpose : operand/result handshake bundle for gcd_calculator.
// Latency : n/a (wires only).
// Backpressure: i_valid/o_ready on the operand side, o_valid/i_ready on the result side.
//
// Signals: i_a, i_b (operands), i_valid/o_ready (operand handshake),
//          o_gcd/o_valid/i_ready (result handshake),
//          o_cycles (CALC cycle count, only with GCD_CYCLE_CNT_EN defined).
interface gcd_calculator_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] i_a;
    logic [DATA_W-1:0] i_b;
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_gcd;
    logic              o_valid;
    logic              i_ready;
`ifdef GCD_CYCLE_CNT_EN
    logic [DATA_W:0]   o_cycles;

    modport slave (
        input  i_a, i_b, i_valid, i_ready,
        output o_ready, o_gcd, o_valid, o_cycles
    );
    modport master (
        output i_a, i_b, i_valid, i_ready,
        input  o_ready, o_gcd, o_valid, o_cycles
    );
`else
    modport slave (
        input  i_a, i_b, i_valid, i_ready,
        output o_ready, o_gcd, o_valid
    );
    modport master (
        output i_a, i_b, i_valid, i_ready,
        input  o_ready, o_gcd, o_valid
    );
`endif
endinterface

// File: rtl/gcd_calculator.sv
// Purpose : iterative subtraction-based Euclid GCD engine, one transaction in flight.
// Latency : accept edge + one edge per CALC cycle (subtractions + 1 terminating step).
// Backpressure: o_ready only in IDLE; result held in DONE until i_ready.
//
// Ports: clk (rising edge), rstn (async active-low), bus (gcd_calculator_if.slave).
// Optional macro GCD_CYCLE_CNT_EN adds bus.o_cycles, a saturating CALC cycle counter.
module gcd_calculator #(
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    gcd_calculator_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] gcd_q, gcd_d;
    // Registered ready: stays low while in reset and rises one edge after release.
    logic              rdy_q, rdy_d;
    logic              accept;

    assign accept = (state_q == IDLE) && rdy_q && bus.i_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.i_a;
                    b_d     = bus.i_b;
                    state_d = CALC;
                end
            end
            CALC: begin
                if ((a_q == '0) || (b_q == '0)) begin
                    // One operand zero: the other one is the GCD (0 when both are zero).
                    gcd_d   = a_q | b_q;
                    state_d = DONE;
                end else if (a_q == b_q) begin
                    gcd_d   = a_q;
                    state_d = DONE;
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    assign bus.o_ready = rdy_q;
    assign bus.o_valid = (state_q == DONE);
    assign bus.o_gcd   = gcd_q;

`ifdef GCD_CYCLE_CNT_EN
    localparam logic [DATA_W:0] CNT_ONE = {{DATA_W{1'b0}}, 1'b1};

    logic [DATA_W:0] cycles_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycles_q <= '0;
        end else if (accept) begin
            cycles_q <= '0;
        end else if ((state_q == CALC) && (cycles_q != '1)) begin
            cycles_q <= cycles_q + CNT_ONE;
        end
    end

    assign bus.o_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_gcd_calculator.sv
// Purpose : directed self-checking bench for gcd_calculator.
// Latency : n/a.
// Backpressure: exercises held results with i_ready low.
module tb_gcd_calculator;

    logic clk;
    logic rstn;
    int   compared;
    int   failed;
    int   accepts;

    gcd_calculator_if #(.DATA_W(8)) bus ();

    gcd_calculator #(.DATA_W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rstn && bus.o_ready && bus.i_valid) accepts <= accepts + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int gcd_ref(input int x, input int y);
        int a, b, t;
        a = x;
        b = y;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Accepts one pair from IDLE and waits for o_valid; returns edges counted
    // from (and including) the accept edge. ready_low reports o_ready stayed 0.
    task automatic start_wait(input int a, input int b, output int edges, output bit ready_low);
        bus.i_a     = a[7:0];
        bus.i_b     = b[7:0];
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        bus.i_a     = 8'hAA;
        bus.i_b     = 8'h55;
        edges       = 1;
        ready_low   = 1'b1;
        while (!bus.o_valid && edges < 600) begin
            if (bus.o_ready) ready_low = 1'b0;
            tick();
            edges++;
        end
        if (bus.o_ready) ready_low = 1'b0;
    endtask

    task automatic run(input string tag, input int a, input int b, input int exp_gcd, input int exp_calc);
        int edges;
        bit ready_low;
        bus.i_ready = 1'b1;
        start_wait(a, b, edges, ready_low);
        check({tag, "_latency"}, edges, exp_calc + 1);
        check({tag, "_gcd"}, bus.o_gcd, exp_gcd);
        check({tag, "_ready_low"}, ready_low, 1);
`ifdef GCD_CYCLE_CNT_EN
        check({tag, "_cycles"}, bus.o_cycles, exp_calc);
`endif
        tick();
        check({tag, "_idle_valid"}, bus.o_valid, 0);
        check({tag, "_idle_ready"}, bus.o_ready, 1);
        check({tag, "_gcd_kept"}, bus.o_gcd, exp_gcd);
    endtask

    initial begin
        int edges;
        int acc0;
        int ra, rb;
        bit ready_low;
        bit hold_ok;

        compared    = 0;
        failed      = 0;
        accepts     = 0;
        rstn        = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;

        // Reset
        repeat (10) tick();
        check("rst_ready", bus.o_ready, 0);
        check("rst_valid", bus.o_valid, 0);
        check("rst_gcd", bus.o_gcd, 0);
        rstn = 1'b1;
        #1;
        check("rel_ready_before_edge", bus.o_ready, 0);
        tick();
        check("rel_ready_after_edge", bus.o_ready, 1);

        // Basic and boundary vectors
        run("g12_8", 12, 8, 4, 3);
        run("g0_9", 0, 9, 9, 1);
        run("g7_0", 7, 0, 7, 1);
        run("g0_0", 0, 0, 0, 1);
        run("g13_13", 13, 13, 13, 1);

        // Backpressure: (15,10) -> 5 after 3 CALC cycles, then held
        bus.i_ready = 1'b0;
        start_wait(15, 10, edges, ready_low);
        check("bp_latency", edges, 4);
        check("bp_gcd", bus.o_gcd, 5);
`ifdef GCD_CYCLE_CNT_EN
        check("bp_cycles", bus.o_cycles, 3);
`endif
        hold_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.o_valid !== 1'b1 || bus.o_gcd !== 8'd5 || bus.o_ready !== 1'b0) hold_ok = 1'b0;
`ifdef GCD_CYCLE_CNT_EN
            if (bus.o_cycles !== 9'd3) hold_ok = 1'b0;
`endif
        end
        check("bp_hold", hold_ok, 1);
        bus.i_ready = 1'b1;
        tick();
        check("bp_release_valid", bus.o_valid, 0);
        check("bp_release_ready", bus.o_ready, 1);

        // Worst case
        run("g255_1", 255, 1, 1, 255);

        // Back-to-back with i_valid held high
        acc0        = accepts;
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        for (int t = 0; t < 25; t++) begin
            edges = 0;
            while (!bus.o_ready && edges < 600) begin
                tick();
                edges++;
            end
            ra = $urandom_range(15, 0);
            rb = $urandom_range(15, 0);
            bus.i_a = ra[7:0];
            bus.i_b = rb[7:0];
            tick();
            bus.i_a = 8'hFF;
            bus.i_b = 8'h0F;
            edges = 0;
            while (!bus.o_valid && edges < 600) begin
                tick();
                edges++;
            end
            check($sformatf("b2b_%0d_%0d_gcd", ra, rb), bus.o_gcd, gcd_ref(ra, rb));
            tick();
        end
        bus.i_valid = 1'b0;
        tick();
        check("b2b_accepts", accepts - acc0, 25);

        // Abort mid-CALC
        bus.i_a     = 8'd200;
        bus.i_b     = 8'd3;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        repeat (10) tick();
        check("abort_busy_valid", bus.o_valid, 0);
        rstn = 1'b0;
        #1;
        check("abort_ready", bus.o_ready, 0);
        check("abort_valid", bus.o_valid, 0);
        check("abort_gcd", bus.o_gcd, 0);
`ifdef GCD_CYCLE_CNT_EN
        check("abort_cycles", bus.o_cycles, 0);
`endif
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        check("abort_rel_ready", bus.o_ready, 1);
        run("g9_6", 9, 6, 3, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/gcd_calculator.md
Name: gcd_calculator

Overview:
Iterative greatest-common-divisor engine for unsigned operands, built on subtraction-based Euclid.
- Accepts an operand pair over a valid/ready input handshake.
- Computes over multiple cycles.
- Returns the result over a valid/ready output handshake.
- Sits as a standalone arithmetic accelerator between a producer and a consumer; one transaction in flight at a time.

Parameters:
DATA_W, 8, operand and result width in bits (unsigned).

Ports:
clk  input  1  system clock, rising-edge active
rstn  input  1  asynchronous active-low reset
i_a  input  DATA_W  operand A, sampled on input handshake
i_b  input  DATA_W  operand B, sampled on input handshake
i_valid  input  1  producer has a valid operand pair
o_ready  output  1  block can accept operands
o_gcd  output  DATA_W  GCD result
o_valid  output  1  o_gcd holds a valid result
i_ready  input  1  consumer accepts the result

Behaviour:
- Clocking/reset: one clock, clk; rstn asynchronous, active-low. While rstn=0: state=IDLE, o_ready=0, o_valid=0, o_gcd=0, internal A/B regs=0. o_ready goes to 1 on the first clock edge after rstn deasserts.
- States: IDLE, CALC, DONE.
- IDLE:
  - o_ready=1, o_valid=0.
  - On rising edge with i_valid=1: load A<=i_a, B<=i_b; go to CALC.
- CALC (o_ready=0, o_valid=0), one step per cycle:
  - If A==0 or B==0: o_gcd<=A|B; go to DONE.
  - Else if A==B: o_gcd<=A; go to DONE.
  - Else if A>B: A<=A-B.
  - Else: B<=B-A.
- DONE:
  - o_valid=1; o_gcd held stable.
  - Rising edge with i_ready=1: go to IDLE.
  - i_ready=0: hold DONE indefinitely, o_gcd unchanged.
- Latency:
  - Input handshake edge -> o_valid high = number of CALC cycles (subtraction steps + 1 terminating cycle) + 1 edge.
  - Example (12,8): CALC cycles = 3.
  - Worst case DATA_W=8 is (255,1) or (1,255): 255 CALC cycles.
- Throughput: after the output handshake, at least one IDLE cycle with o_ready=1 before the next accept.
- Boundary values: gcd(0,x)=x; gcd(x,0)=x; gcd(0,0)=0 (1 CALC cycle); gcd(x,x)=x.
- Arithmetic: all values unsigned DATA_W bits; subtraction never underflows because the larger operand is always the minuend.
- Handshakes:
  - i_a/i_b ignored outside IDLE.
  - i_ready ignored outside DONE.
  - o_gcd keeps its last result after returning to IDLE until the next result is written.
- Reset mid-operation: rstn low in CALC or DONE aborts immediately; all outputs return to reset values; the partial result is discarded.

Optional Feature:
- Macro: GCD_CYCLE_CNT_EN.
- Defined:
  - Adds output port o_cycles, DATA_W+1 bits.
  - Counts CALC cycles of the current transaction, saturating at its maximum value.
  - Cleared on input handshake and at reset.
  - Valid and stable while o_valid=1; holds its value in IDLE.
- Undefined: port o_cycles and counter absent; all other behaviour identical.

Test Plan:
- Reset: hold rstn=0 for 10 cycles -> o_ready=0, o_valid=0, o_gcd=0; one edge after release o_ready=1.
- Basic: (12,8) with i_ready=1 -> o_gcd=4, o_valid 4 edges after accept, o_ready=0 throughout; with GCD_CYCLE_CNT_EN, o_cycles=3.
- Zeros and equal operands:
  - (0,9) -> 9
  - (7,0) -> 7
  - (0,0) -> 0
  - (13,13) -> 13
  - Each of these takes 1 CALC cycle.
- Backpressure: (15,10) with i_ready=0 for 20 cycles -> o_valid stays 1, o_gcd=5 stable, o_ready=0; raising i_ready returns to IDLE after 1 edge.
- Worst case and back-to-back:
  - (255,1) -> o_gcd=1 after 255 CALC cycles.
  - Then 25 random pairs in 0..15 with i_valid held high -> each result matches a reference GCD model, one accept per transaction.
- Abort: assert rstn=0 mid-CALC of (200,3) -> outputs reset immediately; next transaction (9,6) -> o_gcd=3.
